btb_update_scheduler: RTL and testbench

//  Shares the single BTB write port between two producers of branch targets:
//  - EX-stage resolved branches.
//  - ID-stage direct jumps (JAL).

---
 rtl/btb_ctrl_pkg.sv | 15 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/btb_update_scheduler.sv | 132 +++++++++++++
 tb/tb_btb_update_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_ctrl_pkg.sv
// Shared types for the BTB update path: the queued update record
// and the requester id used by the round-robin arbiter.
package btb_ctrl_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
    } btb_upd_t;

    typedef enum logic {
        REQ_EX = 1'b0,
        REQ_ID = 1'b1
    } btb_req_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a clear, used as the BTB update queue.
// Ports: clk/rst, push+din, pop, clear, dout (head), full, empty, count.
module sync_fifo
    import btb_ctrl_pkg::*;
#(
    parameter type T     = btb_upd_t,
    parameter int  DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  T                           din,
    input  logic                       pop,
    input  logic                       clear,
    output T                           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;

    // Storage is not reset; the count alone says what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt_q;
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/btb_update_scheduler.sv
// Arbitrates EX resolved branches and ID jumps onto the single BTB
// write port: round-robin grant, duplicate filter, queue, 1/cycle drain.
// Ports: ex_*/id_* request sides, flush/hold controls, btb_update_*
// write port, occupancy (queued entries), filtered_count (dups dropped).
module btb_update_scheduler
    import btb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    output logic                       ex_ready,
    input  logic [31:0]                ex_pc,
    input  logic [31:0]                ex_target,
    input  logic                       ex_is_branch,
    input  logic                       id_valid,
    output logic                       id_ready,
    input  logic [31:0]                id_pc,
    input  logic [31:0]                id_target,
    input  logic                       flush,
    input  logic                       hold,
    output logic                       btb_update_en,
    output logic [31:0]                btb_update_pc,
    output logic [31:0]                btb_update_target,
    output logic                       btb_update_is_branch,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           filtered_count
);

    localparam int OW = $clog2(DEPTH+1);
    localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

    btb_req_e        rr_q;
    logic            last_valid_q;
    btb_upd_t        last_q;
    logic [CNT_W-1:0] cnt_q;

    logic     can_accept;
    logic     grant_ex;
    logic     grant_id;
    logic     accepted;
    logic     req_is_branch;
    logic     dup;
    logic     push;
    logic     pop;
    btb_upd_t req;
    btb_upd_t head;
    logic     fifo_full;
    logic     fifo_empty;

    // Full blocks acceptance even if the head drains this cycle,
    // keeping ready independent of the drain path.
    assign can_accept = (occupancy < FULL_CNT) && !flush;

    assign grant_ex = ex_valid && can_accept
                   && (!id_valid || rr_q == REQ_EX);
    assign grant_id = id_valid && can_accept
                   && (!ex_valid || rr_q == REQ_ID);

    assign ex_ready = grant_ex;
    assign id_ready = grant_id;
    assign accepted = grant_ex || grant_id;

    always_comb begin
        req           = '0;
        req_is_branch = 1'b0;
        if (grant_ex) begin
            req.pc        = ex_pc;
            req.target    = ex_target;
            req_is_branch = ex_is_branch;
        end else if (grant_id) begin
            req.pc        = id_pc;
            req.target    = id_target;
            req_is_branch = 1'b1;
        end
    end

    // Non-branches are swallowed without touching the filter history.
    assign dup  = last_valid_q && (req == last_q);
    assign push = accepted && req_is_branch && !dup;
    assign pop  = !fifo_empty && !hold && !flush;

    sync_fifo #(
        .T     (btb_upd_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (req),
        .pop   (pop),
        .clear (flush),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q         <= REQ_EX;
            last_valid_q <= 1'b0;
            last_q       <= '0;
            cnt_q        <= '0;
        end else begin
            if (grant_ex) begin
                rr_q <= REQ_ID;
            end else if (grant_id) begin
                rr_q <= REQ_EX;
            end
            if (flush) begin
                last_valid_q <= 1'b0;
            end else if (push) begin
                last_valid_q <= 1'b1;
                last_q       <= req;
            end
            if (accepted && req_is_branch && dup && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Data is gated so the port reads all-zero whenever idle.
    assign btb_update_en        = pop;
    assign btb_update_pc        = pop ? head.pc : 32'h0;
    assign btb_update_target    = pop ? head.target : 32'h0;
    assign btb_update_is_branch = pop;
    assign filtered_count       = cnt_q;

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Directed self-checking bench for btb_update_scheduler.
// A second instance with a 2-bit counter exercises saturation.
module tb_btb_update_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_branch, id_valid, flush, hold;
    logic [31:0] ex_pc, ex_target, id_pc, id_target;
    logic        ex_ready, id_ready;
    logic        en, isb;
    logic [31:0] upc, utgt;
    logic [2:0]  occ;
    logic [15:0] fcnt;
    logic        s_ex_ready, s_id_ready, s_en, s_isb;
    logic [31:0] s_upc, s_utgt;
    logic [2:0]  s_occ;
    logic [1:0]  s_fcnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btb_update_scheduler #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_is_branch(ex_is_branch),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_target(id_target), .flush(flush), .hold(hold),
        .btb_update_en(en), .btb_update_pc(upc),
        .btb_update_target(utgt), .btb_update_is_branch(isb),
        .occupancy(occ), .filtered_count(fcnt)
    );

    btb_update_scheduler #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(s_ex_ready), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_is_branch(ex_is_branch),
        .id_valid(id_valid), .id_ready(s_id_ready), .id_pc(id_pc),
        .id_target(id_target), .flush(flush), .hold(hold),
        .btb_update_en(s_en), .btb_update_pc(s_upc),
        .btb_update_target(s_utgt), .btb_update_is_branch(s_isb),
        .occupancy(s_occ), .filtered_count(s_fcnt)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic ex_req(input logic [31:0] pc, input logic [31:0] tg);
        ex_valid  = 1'b1;
        ex_pc     = pc;
        ex_target = tg;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic idle();
        ex_valid     = 1'b0;
        id_valid     = 1'b0;
        ex_is_branch = 1'b1;
        flush        = 1'b0;
        hold         = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] pc,
                                input logic [31:0] tg);
        check({tag, "_en"}, 64'(en), 64'd1);
        check({tag, "_isb"}, 64'(isb), 64'd1);
        check({tag, "_pc"}, 64'(upc), 64'(pc));
        check({tag, "_tgt"}, 64'(utgt), 64'(tg));
    endtask

    initial begin
        ex_pc = '0; ex_target = '0; id_pc = '0; id_target = '0;
        idle();
        do_reset();

        // 1: reset state, then single EX update
        settle();
        check("rst_occ", 64'(occ), 64'd0);
        check("rst_en", 64'(en), 64'd0);
        check("rst_pc", 64'(upc), 64'd0);
        check("rst_fcnt", 64'(fcnt), 64'd0);
        ex_req(32'h100, 32'h200);
        settle();
        check("t1_ready", 64'(ex_ready), 64'd1);
        check("t1_noby", 64'(en), 64'd0);
        tick();
        ex_valid = 1'b0;
        settle();
        expect_write("t1_wr", 32'h100, 32'h200);
        check("t1_occ1", 64'(occ), 64'd1);
        tick();
        check("t1_occ0", 64'(occ), 64'd0);
        check("t1_en0", 64'(en), 64'd0);

        // 2: round-robin under hold, fill, then ordered drain
        do_reset();
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ex_req(32'h1000 + 32'(k * 16), 32'h2000 + 32'(k * 16));
            id_valid  = 1'b1;
            id_pc     = 32'h3000 + 32'(k * 16);
            id_target = 32'h4000 + 32'(k * 16);
            settle();
            check($sformatf("t2_exr%0d", k), 64'(ex_ready),
                  64'((k % 2) == 0));
            check($sformatf("t2_idr%0d", k), 64'(id_ready),
                  64'((k % 2) == 1));
            tick();
        end
        settle();
        check("t2_occ4", 64'(occ), 64'd4);
        check("t2_exfull", 64'(ex_ready), 64'd0);
        check("t2_idfull", 64'(id_ready), 64'd0);
        check("t2_hold_en", 64'(en), 64'd0);
        idle();
        settle();
        expect_write("t2_w0", 32'h1000, 32'h2000);
        tick();
        expect_write("t2_w1", 32'h3010, 32'h4010);
        tick();
        expect_write("t2_w2", 32'h1020, 32'h2020);
        tick();
        expect_write("t2_w3", 32'h3030, 32'h4030);
        tick();
        check("t2_occ0", 64'(occ), 64'd0);

        // 3: duplicate filter
        ex_req(32'h100, 32'h200);
        settle();
        check("t3_r0", 64'(ex_ready), 64'd1);
        tick();
        settle();
        check("t3_r1", 64'(ex_ready), 64'd1);
        expect_write("t3_w", 32'h100, 32'h200);
        tick();
        check("t3_r2", 64'(ex_ready), 64'd1);
        check("t3_en_dup", 64'(en), 64'd0);
        tick();
        ex_valid = 1'b0;
        settle();
        check("t3_en_dup2", 64'(en), 64'd0);
        check("t3_fcnt", 64'(fcnt), 64'd2);
        check("t3_sfcnt", 64'(s_fcnt), 64'd2);
        ex_req(32'h100, 32'h204);
        tick();
        ex_valid = 1'b0;
        settle();
        expect_write("t3_new", 32'h100, 32'h204);
        tick();

        // 4: flush discards queue and clears filter history
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ex_req(32'h500 + 32'(k * 16), 32'h600 + 32'(k * 16));
            tick();
        end
        settle();
        check("t4_occ3", 64'(occ), 64'd3);
        flush = 1'b1;
        ex_req(32'h530, 32'h630);
        settle();
        check("t4_flrdy", 64'(ex_ready), 64'd0);
        check("t4_flen", 64'(en), 64'd0);
        tick();
        flush = 1'b0;
        hold  = 1'b0;
        ex_req(32'h520, 32'h620);
        settle();
        check("t4_occ0", 64'(occ), 64'd0);
        check("t4_rdy", 64'(ex_ready), 64'd1);
        tick();
        ex_valid = 1'b0;
        settle();
        check("t4_occ1", 64'(occ), 64'd1);
        expect_write("t4_w", 32'h520, 32'h620);
        check("t4_fcnt", 64'(fcnt), 64'd2);
        tick();

        // 5: non-branch accepted and discarded
        ex_req(32'h700, 32'h800);
        ex_is_branch = 1'b0;
        settle();
        check("t5_rdy", 64'(ex_ready), 64'd1);
        tick();
        ex_valid = 1'b0;
        settle();
        check("t5_en", 64'(en), 64'd0);
        check("t5_occ", 64'(occ), 64'd0);
        check("t5_fcnt", 64'(fcnt), 64'd2);
        ex_is_branch = 1'b1;
        ex_req(32'h700, 32'h800);
        tick();
        ex_valid = 1'b0;
        settle();
        check("t5_stored", 64'(occ), 64'd1);
        tick();

        // 6: no full bypass, then counter saturation
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ex_req(32'h800 + 32'(k * 16), 32'h880 + 32'(k * 16));
            tick();
        end
        hold = 1'b0;
        ex_req(32'h900, 32'hA00);
        settle();
        check("t6_fullrdy", 64'(ex_ready), 64'd0);
        expect_write("t6_w0", 32'h800, 32'h880);
        tick();
        check("t6_occ3", 64'(occ), 64'd3);
        check("t6_rdy", 64'(ex_ready), 64'd1);
        tick();
        ex_valid = 1'b0;
        settle();
        check("t6_occpp", 64'(occ), 64'd3);
        expect_write("t6_w1", 32'h820, 32'h8A0);
        tick();
        tick();
        expect_write("t6_w3", 32'h900, 32'hA00);
        tick();
        check("t6_occ0", 64'(occ), 64'd0);
        ex_req(32'h900, 32'hA00);
        tick();
        tick();
        tick();
        ex_valid = 1'b0;
        settle();
        check("t6_fcnt", 64'(fcnt), 64'd5);
        check("t6_sat", 64'(s_fcnt), 64'd3);
        check("t6_en", 64'(en), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
